// File: rtl/debug_unit_ctrl.sv
// UART debug/loader controller: loads instruction memory, runs or single-steps
// the core through its clock-enable, and reports the PC back over UART.
module debug_unit_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_CNT  = 16,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_imem_we,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_data,
  output logic               o_cpu_en,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_pc
);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] RSP_ACK  = NB_BYTE'(8'h06);
  localparam logic [NB_BYTE-1:0] RSP_NAK  = NB_BYTE'(8'h15);

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT_LO, LOAD_CNT_HI, LOAD_DATA, LOAD_WR,
    RUN, STEP, SEND_PC, SEND_ACK, WAIT_TX
  } state_t;

  state_t              state, state_nxt;
  logic [NB_BYTE-1:0]  cnt_lo;
  logic [NB_CNT-1:0]   words_left;
  logic [NB_CNT-1:0]   cnt_full;
  logic [1:0]          byte_idx;
  logic [NB_ADDR-1:0]  addr;
  logic [NB_DATA-1:0]  data;
  logic [NB_DATA-1:0]  pc_lat;
  logic [NB_DATA-1:0]  pc_src;
  logic [NB_BYTE-1:0]  pc_byte;
  logic [1:0]          tx_idx;
  logic                tx_pc;
  logic [NB_BYTE-1:0]  ack_code;
  logic [NB_BYTE-1:0]  tx_hold;

  assign cnt_full = NB_CNT'({i_rx_data, cnt_lo});

  // The PC is captured during the first SEND_PC cycle rather than on the
  // transition edge, so the value reflects the last enabled pipeline cycle.
  assign pc_src  = (tx_idx == 2'd0) ? i_pc : pc_lat;
  assign pc_byte = pc_src[int'(tx_idx)*NB_BYTE +: NB_BYTE];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD)      state_nxt = LOAD_CNT_LO;
          else if (i_rx_data == CMD_RUN)  state_nxt = i_halt ? SEND_PC : RUN;
          else if (i_rx_data == CMD_STEP) state_nxt = i_halt ? SEND_PC : STEP;
          else                            state_nxt = SEND_ACK;
        end
      end
      LOAD_CNT_LO: if (i_rx_valid) state_nxt = LOAD_CNT_HI;
      LOAD_CNT_HI: if (i_rx_valid) state_nxt = (cnt_full == '0) ? SEND_ACK : LOAD_DATA;
      LOAD_DATA:   if (i_rx_valid && byte_idx == 2'd3) state_nxt = LOAD_WR;
      LOAD_WR:     state_nxt = (words_left == NB_CNT'(1)) ? SEND_ACK : LOAD_DATA;
      RUN:         if (i_halt) state_nxt = SEND_PC;
      STEP:        state_nxt = SEND_PC;
      SEND_PC,
      SEND_ACK:    state_nxt = WAIT_TX;
      WAIT_TX:     if (i_tx_done) state_nxt = (tx_pc && tx_idx != 2'd3) ? SEND_PC : IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      addr       <= '0;
      data       <= '0;
      pc_lat     <= '0;
      tx_idx     <= '0;
      tx_pc      <= 1'b0;
      ack_code   <= '0;
      tx_hold    <= '0;
    end else begin
      unique case (state)
        IDLE: if (i_rx_valid) begin
          addr     <= '0;
          byte_idx <= '0;
          tx_idx   <= '0;
          ack_code <= (i_rx_data == CMD_LOAD) ? RSP_ACK : RSP_NAK;
          tx_pc    <= (i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP);
        end
        LOAD_CNT_LO: if (i_rx_valid) cnt_lo <= i_rx_data;
        LOAD_CNT_HI: if (i_rx_valid) words_left <= cnt_full;
        LOAD_DATA: if (i_rx_valid) begin
          data[int'(byte_idx)*NB_BYTE +: NB_BYTE] <= i_rx_data;
          byte_idx <= byte_idx + 2'd1;
        end
        LOAD_WR: begin
          addr       <= addr + NB_ADDR'(1);
          words_left <= words_left - NB_CNT'(1);
        end
        SEND_PC: begin
          if (tx_idx == 2'd0) pc_lat <= i_pc;
          tx_hold <= pc_byte;
        end
        SEND_ACK: tx_hold <= ack_code;
        WAIT_TX:  if (i_tx_done) tx_idx <= tx_idx + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_imem_we   = (state == LOAD_WR);
    o_imem_addr = addr;
    o_imem_data = data;
    o_cpu_en    = (state == RUN) || (state == STEP);
    o_tx_start  = (state == SEND_PC) || (state == SEND_ACK);
    o_tx_data   = tx_hold;
    if (state == SEND_PC)       o_tx_data = pc_byte;
    else if (state == SEND_ACK) o_tx_data = ack_code;
  end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed bench for debug_unit_ctrl: program load, run, step, NAK and reset
// scenarios with a UART transmitter responder and a simple PC model.
module tb_debug_unit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        cpu_en;
  logic        halt;
  logic [31:0] pc;

  always #5 clk = ~clk;

  debug_unit_ctrl #(.NB_DATA(32), .NB_ADDR(10), .NB_CNT(16), .NB_BYTE(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
    .o_cpu_en(cpu_en), .i_halt(halt), .i_pc(pc)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  tx_q[$];
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [9:0]  pa_q[$];
  int          cpu_cycles = 0;
  int          tx_viol = 0;
  bit          tx_busy = 0;
  int          tx_wait = 0;
  logic [7:0]  tx_cur = '0;
  bit          we_prev = 0;

  // PC model: advances by 4 on every enabled pipeline cycle when pc_inc is set
  logic [31:0] pc_base = '0;
  bit          pc_inc = 0;
  int          pc_steps = 0;
  assign pc = pc_base + 32'(pc_steps * 4);
  always @(posedge clk) if (pc_inc && cpu_en) pc_steps <= pc_steps + 1;

  // Transmitter responder and write/enable recorder
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_busy = 0;
      we_prev = 0;
    end else begin
      if (we_prev) pa_q.push_back(imem_addr);
      we_prev = imem_we;
      if (imem_we) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_data);
      end
      if (cpu_en) cpu_cycles++;
      if (tx_busy) begin
        if (tx_start || tx_data !== tx_cur) tx_viol++;
        if (tx_wait == 0) begin
          tx_done = 1'b1;
          tx_busy = 0;
        end else tx_wait--;
      end else if (tx_start) begin
        tx_q.push_back(tx_data);
        tx_cur  = tx_data;
        tx_busy = 1;
        tx_wait = 3;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_q.size() >= target && !tx_busy) begin
        timed_out = 0;
        break;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; halt = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_data, tx_start, imem_we, imem_addr, imem_data, cpu_en} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%b/%h/%h/%b required=all zero",
               tx_data, tx_start, imem_we, imem_addr, imem_data, cpu_en);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_q.size() != 0 || cpu_cycles != 0 || wa_q.size() != 0) begin
      failures++;
      $display("FAIL reset_idle got tx=%0d en=%0d wr=%0d required=0/0/0",
               tx_q.size(), cpu_cycles, wa_q.size());
    end
  endtask

  task automatic test_load_two;
    logic [7:0] seq [11] = '{8'h4C, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00};
    int wb = wa_q.size(), pb = pa_q.size(), tb = tx_q.size(), cb = cpu_cycles;
    bit to;
    foreach (seq[i]) send_byte(seq[i]);
    wait_tx(tb + 1, to);
    checks++;
    if (to) begin failures++; $display("FAIL load2_timeout got=timeout required=ack"); end
    checks++;
    if (wa_q.size() - wb != 2) begin
      failures++; $display("FAIL load2_wr_count got=%0d required=2", wa_q.size() - wb);
    end else begin
      checks++;
      if (wa_q[wb] !== 10'd0 || wd_q[wb] !== 32'h00100513) begin
        failures++; $display("FAIL load2_word0 got=%h@%h required=00100513@000", wd_q[wb], wa_q[wb]);
      end
      checks++;
      if (wa_q[wb+1] !== 10'd1 || wd_q[wb+1] !== 32'h00200593) begin
        failures++; $display("FAIL load2_word1 got=%h@%h required=00200593@001", wd_q[wb+1], wa_q[wb+1]);
      end
      checks++;
      if (pa_q[pb] !== 10'd1 || pa_q[pb+1] !== 10'd2) begin
        failures++; $display("FAIL load2_addr_inc got=%h,%h required=001,002", pa_q[pb], pa_q[pb+1]);
      end
    end
    checks++;
    if (tx_q.size() - tb != 1 || tx_q[tb] !== 8'h06) begin
      failures++; $display("FAIL load2_ack got=%0d bytes first=%h required=1 byte 06", tx_q.size() - tb, tx_q[tb]);
    end
    checks++;
    if (cpu_cycles != cb) begin
      failures++; $display("FAIL load2_cpu_en got=%0d required=0", cpu_cycles - cb);
    end
  endtask

  task automatic test_load_zero;
    int wb = wa_q.size(), tb = tx_q.size();
    bit to;
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    wait_tx(tb + 1, to);
    checks++;
    if (to || tx_q.size() - tb != 1 || tx_q[tb] !== 8'h06) begin
      failures++; $display("FAIL load0_ack got=%0d bytes first=%h required=1 byte 06", tx_q.size() - tb, tx_q[tb]);
    end
    checks++;
    if (wa_q.size() != wb) begin
      failures++; $display("FAIL load0_writes got=%0d required=0", wa_q.size() - wb);
    end
  endtask

  task automatic test_nak;
    int wb = wa_q.size(), tb = tx_q.size(), cb = cpu_cycles;
    bit to;
    send_byte(8'h7A);
    wait_tx(tb + 1, to);
    checks++;
    if (to || tx_q.size() - tb != 1 || tx_q[tb] !== 8'h15) begin
      failures++; $display("FAIL nak_byte got=%0d bytes first=%h required=1 byte 15", tx_q.size() - tb, tx_q[tb]);
    end
    checks++;
    if (wa_q.size() != wb || cpu_cycles != cb) begin
      failures++; $display("FAIL nak_side_effects got wr=%0d en=%0d required=0/0", wa_q.size() - wb, cpu_cycles - cb);
    end
  endtask

  task automatic test_run;
    logic [7:0] exp [4] = '{8'h50, 8'h00, 8'h00, 8'h00};
    int tb, cb;
    bit to, seen;
    pc_base = 32'h0000_0050; pc_inc = 0; halt = 1'b0;
    tb = tx_q.size(); cb = cpu_cycles;
    send_byte(8'h52);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_en) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL run_enable got=0 required=1"); end
    repeat (19) @(negedge clk);
    halt = 1'b1;
    wait_tx(tb + 4, to);
    halt = 1'b0;
    checks++;
    if (to || tx_q.size() - tb != 4) begin
      failures++; $display("FAIL run_tx_count got=%0d required=4", tx_q.size() - tb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_q[tb+i] !== exp[i]) begin
          failures++; $display("FAIL run_pc_byte%0d got=%h required=%h", i, tx_q[tb+i], exp[i]);
        end
      end
    end
    checks++;
    if (cpu_cycles - cb != 20) begin
      failures++; $display("FAIL run_en_cycles got=%0d required=20", cpu_cycles - cb);
    end
  endtask

  task automatic test_step;
    int tb, cb;
    bit to;
    pc_base = '0; pc_inc = 1; halt = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tb = tx_q.size(); cb = cpu_cycles;
      send_byte(8'h53);
      wait_tx(tb + 4, to);
      checks++;
      if (cpu_cycles - cb != 1) begin
        failures++; $display("FAIL step%0d_en_cycles got=%0d required=1", k, cpu_cycles - cb);
      end
      checks++;
      if (to || tx_q.size() - tb != 4 || tx_q[tb] !== 8'(4 * k) ||
          tx_q[tb+1] !== 8'h00 || tx_q[tb+2] !== 8'h00 || tx_q[tb+3] !== 8'h00) begin
        failures++;
        $display("FAIL step%0d_pc got=%0d bytes %h %h %h %h required=%h 00 00 00", k,
                 tx_q.size() - tb, tx_q[tb], tx_q[tb+1], tx_q[tb+2], tx_q[tb+3], 8'(4 * k));
      end
    end
    pc_inc = 0;
  endtask

  task automatic test_step_halted;
    int tb = tx_q.size(), cb = cpu_cycles;
    bit to;
    halt = 1'b1;
    send_byte(8'h53);
    wait_tx(tb + 4, to);
    halt = 1'b0;
    checks++;
    if (cpu_cycles != cb) begin
      failures++; $display("FAIL step_halt_en got=%0d required=0", cpu_cycles - cb);
    end
    checks++;
    if (to || tx_q.size() - tb != 4 || tx_q[tb] !== 8'h0C || tx_q[tb+1] !== 8'h00 ||
        tx_q[tb+2] !== 8'h00 || tx_q[tb+3] !== 8'h00) begin
      failures++;
      $display("FAIL step_halt_pc got=%0d bytes %h %h %h %h required=0c 00 00 00",
               tx_q.size() - tb, tx_q[tb], tx_q[tb+1], tx_q[tb+2], tx_q[tb+3]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pre [9] = '{8'h4C, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    logic [7:0] post [7] = '{8'h4C, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    int wb, tb;
    bit to, seen;
    foreach (pre[i]) send_byte(pre[i]);
    checks++;
    if (imem_addr !== 10'd1) begin
      failures++; $display("FAIL midload_addr got=%h required=001", imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_start, imem_we, imem_addr, imem_data, cpu_en} !== '0) begin
      failures++;
      $display("FAIL midload_reset got=%h/%b/%b/%h/%h/%b required=all zero",
               tx_data, tx_start, imem_we, imem_addr, imem_data, cpu_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wb = wa_q.size(); tb = tx_q.size();
    foreach (post[i]) send_byte(post[i]);
    wait_tx(tb + 1, to);
    checks++;
    if (wa_q.size() - wb != 1 || wa_q[wb] !== 10'd0 || wd_q[wb] !== 32'h44332211) begin
      failures++; $display("FAIL reload_word got=%0d writes %h@%h required=1 write 44332211@000",
                           wa_q.size() - wb, wd_q[wb], wa_q[wb]);
    end
    checks++;
    if (to || tx_q.size() - tb != 1 || tx_q[tb] !== 8'h06) begin
      failures++; $display("FAIL reload_ack got=%0d bytes first=%h required=1 byte 06", tx_q.size() - tb, tx_q[tb]);
    end
    // Reset while the core is running must drop the enable without a clock edge
    halt = 1'b0;
    send_byte(8'h52);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_en) begin seen = 1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || cpu_en !== 1'b0) begin
      failures++; $display("FAIL run_reset got seen=%0d en=%b required=1/0", seen, cpu_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_load_two;
    test_load_zero;
    test_nak;
    test_run;
    test_step;
    test_step_halted;
    test_reset_mid;
    checks++;
    if (tx_viol != 0) begin
      failures++; $display("FAIL tx_handshake got=%0d violations required=0", tx_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
